shift_register_univ: RTL and testbench
======================================

# shift_register_univ

Parametrised universal shift register for the datapath, the next generation of the single-direction shift register. It adds bidirectional logical and arithmetic shifts, rotates, and a manual single-step mode. An auto-sequencing mode performs a programmed number of shifts and signals completion, which the sequential multiply/divide controllers use to drive multi-cycle shift sequences without their own bit counters.

## Interface
- `N`, default 8: register width; legal values are N ≥ 2.
- `CW`, default 4: width of the shift-count input.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset. It is asynchronous and active-high.
- `sin_l` in 1: serial input, entering at bit 0 on a logical left shift.
- `sin_r` in 1: serial input, entering at bit N-1 on a logical right shift.
- `parin` in N: parallel load data.
- `ld` in 1: parallel load.
- `shift_en` in 1: perform one step of `op` this cycle (manual mode).
- `p1` in 1: set bit 0 to 1.
- `op` in 3: shift operation. Encodings are listed under Operation.
- `start` in 1: begin an auto sequence of `cnt` steps of `op`.
- `cnt` in CW: number of steps for the auto sequence.
- `parout` out N: register contents.
- `sout_l` out 1: current data[N-1].
- `sout_r` out 1: current data[0].
- `busy` out 1: auto sequence in progress.
- `done` out 1: one-cycle pulse when an auto sequence completes.

## Operation
- **op encodings:**
  - 000 HOLD.
  - 001 SHL: {d[N-2:0], sin_l}.
  - 010 SHR: {sin_r, d[N-1:1]}.
  - 011 SRA: {d[N-1], d[N-1:1]}.
  - 100 ROL: {d[N-2:0], d[N-1]}.
  - 101 ROR: {d[0], d[N-1:1]}.
  - 110 and 111: HOLD.
- **FSM states:**
  - IDLE: manual controls are active.
  - RUN: auto shifting.
  - DONE: one cycle, `done`=1.
- **Manual priority in IDLE**, at each edge: `ld` > `start` > `shift_en` > `p1`. Exactly one action is taken.
  - `ld`: data ← parin.
  - `shift_en`: data ← step(op).
  - `p1`: data[0] ← 1, other bits unchanged.
- **`start` in IDLE** (with `ld`=0):
  - The block latches `op` into op_q and `cnt` into rem.
  - Next state is RUN if cnt≠0, otherwise DONE.
  - No shift happens on the start edge.
- **RUN:**
  - Each edge: data ← step(op_q), rem ← rem-1.
  - When rem==1 at the edge, the next state is DONE.
- **DONE:** always returns to IDLE on the next edge. Inputs are ignored in DONE.
- **While in RUN:** `ld`, `start`, `shift_en`, `p1`, `op` and `cnt` are ignored. The latched op_q is the only operation used.
- **Serial outputs:** `sout_l` and `sout_r` reflect current data, so a serial chain sees the outgoing bit before the shifting edge.
- **Serial inputs:** `sin_l` and `sin_r` are sampled live every RUN cycle; they are not latched.

## Timing
- **Reset values:**
  - data, `parout`: 0.
  - `sout_l`, `sout_r`: 0.
  - `busy`, `done`: 0.
  - state IDLE, rem 0, op_q 000.
- **Reset mid-sequence:** asserting `rst` during RUN or DONE aborts immediately. Everything returns to reset values, and no `done` pulse is issued.
- **Auto sequence, start sampled at edge t0 with cnt=k>0:**
  - `busy`=1 for the k cycles after t0.
  - Shifts occur at edges t1..tk.
  - `done`=1 in the cycle after tk.
  - `parout` already holds the final value while `done` is high.
  - Earliest next `start` is sampled at edge tk+2.
- **cnt=0:** `done`=1 in the cycle after t0, `busy` stays 0, data is unchanged.
- **cnt ≥ N:** no saturation. ROL/ROR wrap modulo N, SHL/SHR keep inserting serial bits, and SRA settles to all-sign.
- **Outputs:** `busy` and `done` are Moore outputs decoded from state only. `parout`, `sout_l` and `sout_r` come directly from the data register.

## Structure
- **Package `shift_pkg`** holds:
  - the op encodings, as localparams or an enum.
  - the FSM state enum (IDLE, RUN, DONE).
- **Sub-module `shift_step`:** combinational, parametrised by N. It takes (d, op, sin_l, sin_r) and returns next d. It is shared by the manual and auto paths.
- **Top level** holds the data register, rem counter, op_q and FSM.

## Test plan
- **Reset:** load 0xA5, then start with cnt=5 and op=ROL. Assert `rst` 2 cycles in. Required: `parout`=0x00, `busy`=0, and no `done` pulse afterwards.
- **Manual shifts:**
  - ld 0x96, then shift_en with op=SHL and sin_l=1: `parout`=0x2D. `sout_l` read 1 before the shift edge.
  - Then op=SHR with sin_r=0: `parout`=0x16.
- **Auto SRA:** ld 0x80, start with op=SRA and cnt=3. Required:
  - `busy` high for exactly 3 cycles.
  - `done` high for 1 cycle with `parout`=0xF0.
  - `busy` low again the cycle after `done`.
- **Rotate wrap:**
  - ld 0x01, start with op=ROR and cnt=8: final value 0x01.
  - ld 0x81, manual ROL: 0x03.
- **Priority:**
  - `ld` + `shift_en` + `p1` together with parin=0x3C: 0x3C.
  - `shift_en` (SHL, sin_l=0) + `p1` on 0x10: 0x20.
  - `p1` alone on 0x10: 0x11.
- **Corner cases:**
  - start with cnt=0: `done` the next cycle, data unchanged, `busy` never 1.
  - During RUN, pulse `ld` with 0xFF and `start`: both ignored, and the sequence result matches an undisturbed run.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: step operations and the
// auto-sequencer state.
package shift_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational step of the selected shift/rotate operation.
// Shared by the manual and auto-sequenced paths.
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] d_i,
    input  logic [2:0]   op_i,
    input  logic         sin_l_i,
    input  logic         sin_r_i,
    output logic [N-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        case (op_i)
            OP_HOLD: d_o = d_i;
            OP_SHL:  d_o = {d_i[N-2:0], sin_l_i};
            OP_SHR:  d_o = {sin_r_i, d_i[N-1:1]};
            OP_SRA:  d_o = {d_i[N-1], d_i[N-1:1]};
            OP_ROL:  d_o = {d_i[N-2:0], d_i[N-1]};
            OP_ROR:  d_o = {d_i[0], d_i[N-1:1]};
            default: d_o = d_i;  // 110/111 are holds
        endcase
    end

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register with manual controls and an auto sequencer that
// performs a programmed number of steps and pulses done on completion.
module shift_register_univ
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sin_l,
    input  logic          sin_r,
    input  logic [N-1:0]  parin,
    input  logic          ld,
    input  logic          shift_en,
    input  logic          p1,
    input  logic [2:0]    op,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    output logic [N-1:0]  parout,
    output logic          sout_l,
    output logic          sout_r,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    step_op;
    logic [N-1:0]  step_data;

    // While running only the latched op is used; live op drives manual steps.
    assign step_op = (state_q == ST_RUN) ? op_q : op;

    shift_step #(.N(N)) u_step (
        .d_i     (data_q),
        .op_i    (step_op),
        .sin_l_i (sin_l),
        .sin_r_i (sin_r),
        .d_o     (step_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_HOLD;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    data_d = parin;
                end else if (start) begin
                    op_d    = op;
                    rem_d   = cnt;
                    state_d = (cnt != '0) ? ST_RUN : ST_DONE;
                end else if (shift_en) begin
                    data_d = step_data;
                end else if (p1) begin
                    data_d[0] = 1'b1;
                end
            end
            ST_RUN: begin
                data_d = step_data;
                rem_d  = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    assign parout = data_q;
    assign sout_l = data_q[N-1];
    assign sout_r = data_q[0];

endmodule

// File: tb/tb_shift_register_univ.sv
// Self-checking bench: directed vector table, hand-written auto sequences and
// randomized traffic against an arithmetic reference model.
module tb_shift_register_univ;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sin_l, sin_r;
    logic [N-1:0]  parin;
    logic          ld, shift_en, p1, start;
    logic [2:0]    op;
    logic [CW-1:0] cnt;
    logic [N-1:0]  parout;
    logic          sout_l, sout_r, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_register_univ #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .parin    (parin),
        .ld       (ld),
        .shift_en (shift_en),
        .p1       (p1),
        .op       (op),
        .start    (start),
        .cnt      (cnt),
        .parout   (parout),
        .sout_l   (sout_l),
        .sout_r   (sout_r),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] pre;
        logic       ld;
        logic       sh;
        logic       p1;
        logic [2:0] op;
        logic       sl;
        logic       sr;
        logic [7:0] parin;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld = 0; shift_en = 0; p1 = 0; start = 0;
        op = 3'b000; cnt = '0; sin_l = 0; sin_r = 0;
    endtask

    task automatic load(input logic [7:0] v);
        ld = 1; parin = v;
        tick();
        ld = 0;
    endtask

    // Reference step, expressed as plain arithmetic on the register value.
    function automatic int ref_step(input int d, input int opc, input int sl, input int sr);
        case (opc)
            1: return (d * 2 + sl) % 256;
            2: return d / 2 + sr * 128;
            3: return d / 2 + ((d >= 128) ? 128 : 0);
            4: return (d * 2) % 256 + d / 128;
            5: return d / 2 + (d % 2) * 128;
            default: return d;
        endcase
    endfunction

    // Auto sequence with fixed serial inputs; optionally pokes manual controls
    // during the first RUN cycle, which must have no effect.
    task automatic run_auto(input string name, input logic [7:0] pre, input logic [2:0] opc,
                            input int k, input logic [7:0] exp, input bit disturb);
        int busy_cycles, done_cycles;
        logic [7:0] final_v;
        bit got, busy_after;
        load(pre);
        op = opc; cnt = CW'(k); start = 1;
        tick();
        start = 0; op = 3'b000; cnt = '0;
        busy_cycles = 0; done_cycles = 0; got = 0; final_v = '0; busy_after = 0;
        for (int c = 0; c < 40; c++) begin
            if (disturb && c == 0) begin
                ld = 1; parin = 8'hFF; start = 1; shift_en = 1; p1 = 1; op = 3'b001; cnt = 4'd2;
            end
            if (disturb && c == 1) idle_inputs();
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                if (!got) begin final_v = parout; got = 1; end
            end
            if (got && !done) begin busy_after = busy; break; end
            tick();
        end
        idle_inputs();
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_busy_cycles"}, busy_cycles, k);
        check({name, "_done_cycles"}, done_cycles, 1);
        check({name, "_final"}, final_v, exp);
        check({name, "_busy_after"}, 32'(busy_after), 32'd0);
        $display("auto %s: op=%0d cnt=%0d final=0x%02h busy_cycles=%0d", name, opc, k, final_v, busy_cycles);
    endtask

    initial begin
        int model;
        idle_inputs();
        parin = '0;
        rst = 1;
        tick(); tick();
        check("reset_parout", parout, 8'h00);
        check("reset_sout_l", sout_l, 1'b0);
        check("reset_sout_r", sout_r, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 0;
        tick();

        // Reset abort mid-sequence.
        load(8'hA5);
        op = 3'b100; cnt = 4'd5; start = 1;
        tick();
        idle_inputs();
        tick();
        rst = 1;
        #2;
        check("abort_parout", parout, 8'h00);
        check("abort_busy", busy, 1'b0);
        tick();
        rst = 0;
        begin
            int done_hits = 0;
            for (int c = 0; c < 10; c++) begin
                if (done || busy) done_hits++;
                tick();
            end
            check("abort_no_done", done_hits, 0);
        end
        $display("reset abort: parout=0x%02h", parout);

        // Serial out reflects data before the shifting edge.
        load(8'h96);
        check("sout_l_pre_shift", sout_l, 1'b1);
        check("sout_r_pre_shift", sout_r, 1'b0);

        vecs[0] = '{"shl_sin1",   8'h96, 0, 1, 0, 3'b001, 1, 0, 8'h00, 8'h2D};
        vecs[1] = '{"shr_sin0",   8'h2D, 0, 1, 0, 3'b010, 0, 0, 8'h00, 8'h16};
        vecs[2] = '{"rol_wrap",   8'h81, 0, 1, 0, 3'b100, 0, 0, 8'h00, 8'h03};
        vecs[3] = '{"ld_wins",    8'h00, 1, 1, 1, 3'b001, 1, 1, 8'h3C, 8'h3C};
        vecs[4] = '{"shift_wins", 8'h10, 0, 1, 1, 3'b001, 0, 0, 8'h00, 8'h20};
        vecs[5] = '{"p1_alone",   8'h10, 0, 0, 1, 3'b001, 0, 0, 8'h00, 8'h11};
        vecs[6] = '{"sra_manual", 8'h80, 0, 1, 0, 3'b011, 0, 0, 8'h00, 8'hC0};
        vecs[7] = '{"ror_manual", 8'h01, 0, 1, 0, 3'b101, 0, 0, 8'h00, 8'h80};
        vecs[8] = '{"op110_hold", 8'h55, 0, 1, 0, 3'b110, 1, 1, 8'h00, 8'h55};
        vecs[9] = '{"shr_sin1",   8'h01, 0, 1, 0, 3'b010, 0, 1, 8'h00, 8'h80};

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].pre);
            ld = vecs[i].ld; shift_en = vecs[i].sh; p1 = vecs[i].p1; op = vecs[i].op;
            sin_l = vecs[i].sl; sin_r = vecs[i].sr; parin = vecs[i].parin;
            tick();
            idle_inputs();
            check(vecs[i].name, parout, vecs[i].exp);
            $display("vec %s: parout=0x%02h", vecs[i].name, parout);
        end

        run_auto("auto_sra", 8'h80, 3'b011, 3, 8'hF0, 0);
        run_auto("auto_ror8", 8'h01, 3'b101, 8, 8'h01, 0);
        run_auto("auto_cnt0", 8'h5A, 3'b001, 0, 8'h5A, 0);
        run_auto("auto_disturb", 8'h81, 3'b100, 4, 8'h18, 1);
        run_auto("auto_sra15", 8'h90, 3'b011, 15, 8'hFF, 0);

        // Randomized traffic against the reference model.
        model = parout;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int opc, k;
                opc = $urandom_range(0, 7);
                k = $urandom_range(0, 15);
                op = 3'(opc); cnt = CW'(k); start = 1;
                shift_en = 1'($urandom); p1 = 1'($urandom);
                tick();
                for (int s = 0; s < k; s++) begin
                    sin_l = 1'($urandom); sin_r = 1'($urandom);
                    ld = 1'($urandom); start = 1'($urandom); parin = 8'($urandom);
                    op = 3'($urandom); shift_en = 1'($urandom); p1 = 1'($urandom);
                    check("rnd_busy", busy, 1'b1);
                    model = ref_step(model, opc, sin_l, sin_r);
                    tick();
                end
                idle_inputs();
                check("rnd_done", done, 1'b1);
                check("rnd_auto_data", parout, 32'(model));
                tick();
                check("rnd_done_clear", {busy, done}, 2'b00);
                $display("rnd auto op=%0d cnt=%0d parout=0x%02h", opc, k, parout);
            end else begin
                ld = ($urandom_range(0, 4) == 0);
                shift_en = 1'($urandom); p1 = 1'($urandom);
                op = 3'($urandom); sin_l = 1'($urandom); sin_r = 1'($urandom);
                parin = 8'($urandom);
                if (ld) model = parin;
                else if (shift_en) model = ref_step(model, op, sin_l, sin_r);
                else if (p1) model = model | 1;
                tick();
                idle_inputs();
                check("rnd_manual", parout, 32'(model));
                check("rnd_sout", {sout_l, sout_r}, {1'(model / 128), 1'(model % 2)});
                $display("rnd manual parout=0x%02h", parout);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
